// File: rtl/fcpu_pkg.sv
// Shared CPU-wide types and widths: common data bus layout and arbitration policy.
package fcpu_pkg;

    localparam int RSV_ID_W = 16;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_t;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Encodes a one-hot vector (up to 16 bits) into its bit index.
    function automatic logic [3:0] oh_idx(input logic [15:0] oh);
        logic [15:0] v;
        logic [3:0]  r;
        v = oh;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[0]) begin
                r = 4'(i);
            end
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection with a registered search pointer; the pointer
// moves one past the granted requester so every requester is served in turn.
module rr_arbiter
    import fcpu_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [N-1:0]          req,
    input  logic                  en,
    output logic [N-1:0]          gnt,
    output logic [idx_w(N)-1:0]   gnt_idx
);

    localparam int IDX_W = idx_w(N);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [N-1:0]     hi_mask;
    logic [N-1:0]     req_hi;
    logic [N-1:0]     pick;
    logic [N-1:0]     gnt_raw;

    // Requests at or above ptr win first; otherwise wrap to the lowest request.
    assign hi_mask = ~((N'(1) << ptr_reg) - N'(1));
    assign req_hi  = req & hi_mask;
    assign pick    = (|req_hi) ? req_hi : req;
    assign gnt_raw = pick & (~pick + N'(1));
    assign gnt     = en ? gnt_raw : '0;
    assign gnt_idx = IDX_W'(oh_idx(16'(gnt_raw)));

    always_comb begin
        ptr_next = ptr_reg;
        if (|gnt) begin
            ptr_next = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one functional-unit result per cycle and
// broadcasts it from a register one cycle later; flush blocks all grants.
module cdb_arbiter
    import fcpu_pkg::*;
#(
    parameter int        N_UNITS  = 3,
    parameter arb_mode_t ARB_MODE = ARB_RR,
    parameter int        CDB_W    = fcpu_pkg::CDB_W
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [N_UNITS*CDB_W-1:0]    units_cdb,
    input  logic [N_UNITS-1:0]          units_cdb_valid,
    output logic [N_UNITS-1:0]          units_cdb_ready,
    input  logic                        flush,
    output logic [CDB_W-1:0]            cdb,
    output logic                        cdb_valid,
    output logic [idx_w(N_UNITS)-1:0]   cdb_src
);

    localparam int SRC_W = idx_w(N_UNITS);

    logic                en;
    logic [N_UNITS-1:0]  gnt;
    logic [SRC_W-1:0]    gnt_idx;
    logic                xfer;
    logic [CDB_W-1:0]    word_sel;

    logic [CDB_W-1:0]    cdb_reg;
    logic                cdb_valid_reg;
    logic [SRC_W-1:0]    cdb_src_reg;

    // Reset is folded in so no ready can escape while nrst is low.
    assign en = nrst & ~flush;

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            rr_arbiter #(
                .N (N_UNITS)
            ) u_rr_arbiter (
                .clk     (clk),
                .nrst    (nrst),
                .req     (units_cdb_valid),
                .en      (en),
                .gnt     (gnt),
                .gnt_idx (gnt_idx)
            );
        end else begin : g_fixed
            logic [N_UNITS-1:0] req_en;
            assign req_en  = units_cdb_valid & {N_UNITS{en}};
            assign gnt     = req_en & (~req_en + N_UNITS'(1));
            assign gnt_idx = SRC_W'(oh_idx(16'(gnt)));
        end
    endgenerate

    assign units_cdb_ready = gnt;
    assign xfer            = |gnt;
    assign word_sel        = CDB_W'(units_cdb >> (int'(gnt_idx) * CDB_W));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cdb_reg       <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_src_reg   <= '0;
        end else begin
            cdb_valid_reg <= xfer;
            if (xfer) begin
                cdb_reg     <= word_sel;
                cdb_src_reg <= gnt_idx;
            end
        end
    end

    assign cdb       = cdb_reg;
    assign cdb_valid = cdb_valid_reg;
    assign cdb_src   = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random checks of cdb_arbiter in RR (N=3, N=5, N=1) and fixed (N=3) builds.
module tb_cdb_arbiter;
    import fcpu_pkg::*;

    localparam int W = fcpu_pkg::CDB_W;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // N=3 round-robin
    logic [3*W-1:0] d3;
    logic [2:0]     v3, r3;
    logic           f3;
    logic [W-1:0]   c3;
    logic           cv3;
    logic [1:0]     s3;
    // N=3 fixed priority
    logic [3*W-1:0] df;
    logic [2:0]     vf, rf;
    logic           ff;
    logic [W-1:0]   cf;
    logic           cvf;
    logic [1:0]     sf;
    // N=5 round-robin
    logic [5*W-1:0] d5;
    logic [4:0]     v5, r5;
    logic           f5;
    logic [W-1:0]   c5;
    logic           cv5;
    logic [2:0]     s5;
    // N=1
    logic [W-1:0]   d1;
    logic           v1, r1, f1;
    logic [W-1:0]   c1;
    logic           cv1;
    logic [0:0]     s1;

    cdb_arbiter #(.N_UNITS(3), .ARB_MODE(ARB_RR)) u_rr (
        .clk(clk), .nrst(nrst), .units_cdb(d3), .units_cdb_valid(v3),
        .units_cdb_ready(r3), .flush(f3), .cdb(c3), .cdb_valid(cv3), .cdb_src(s3));
    cdb_arbiter #(.N_UNITS(3), .ARB_MODE(ARB_FIXED)) u_fx (
        .clk(clk), .nrst(nrst), .units_cdb(df), .units_cdb_valid(vf),
        .units_cdb_ready(rf), .flush(ff), .cdb(cf), .cdb_valid(cvf), .cdb_src(sf));
    cdb_arbiter #(.N_UNITS(5), .ARB_MODE(ARB_RR)) u_five (
        .clk(clk), .nrst(nrst), .units_cdb(d5), .units_cdb_valid(v5),
        .units_cdb_ready(r5), .flush(f5), .cdb(c5), .cdb_valid(cv5), .cdb_src(s5));
    cdb_arbiter #(.N_UNITS(1), .ARB_MODE(ARB_RR)) u_one (
        .clk(clk), .nrst(nrst), .units_cdb(d1), .units_cdb_valid(v1),
        .units_cdb_ready(r1), .flush(f1), .cdb(c1), .cdb_valid(cv1), .cdb_src(s1));

    function automatic logic [W-1:0] w3(input int i);
        return {16'(i + 1), 32'(160 + i)};
    endfunction

    task automatic test_reset();
        nrst = 1'b0;
        d3 = {w3(2), w3(1), w3(0)}; v3 = 3'b111; f3 = 1'b0;
        df = {w3(2), w3(1), w3(0)}; vf = 3'b111; ff = 1'b0;
        d5 = '1; v5 = 5'b11111; f5 = 1'b0;
        d1 = '1; v1 = 1'b1; f1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (r3 !== 3'b000 || rf !== 3'b000 || r5 !== 5'b0 || r1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready got rr=%b fx=%b five=%b one=%b want all 0", r3, rf, r5, r1);
        end
        tests_run++;
        if (cv3 !== 1'b0 || c3 !== '0 || s3 !== 2'd0 || cvf !== 1'b0 || cv5 !== 1'b0 || cv1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got cv=%b cdb=%h src=%0d want 0/0/0", cv3, c3, s3);
        end
        @(negedge clk);
        nrst = 1'b1;
        v3 = '0; vf = '0; v5 = '0; v1 = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_rr_rotate();
        logic [2:0] exp_r;
        @(negedge clk);
        d3 = {w3(2), w3(1), w3(0)};
        v3 = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_r = 3'b001 << (c % 3);
            tests_run++;
            if (r3 !== exp_r) begin
                tests_failed++;
                $display("FAIL rr_rotate_ready c=%0d got %b want %b", c, r3, exp_r);
            end
            tests_run++;
            if (c == 0) begin
                if (cv3 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_rotate_first_cv got %b want 0", cv3);
                end
            end else if (cv3 !== 1'b1 || s3 !== 2'((c - 1) % 3) || c3 !== w3((c - 1) % 3)) begin
                tests_failed++;
                $display("FAIL rr_rotate_bcast c=%0d got cv=%b src=%0d cdb=%h want 1/%0d/%h",
                         c, cv3, s3, c3, (c - 1) % 3, w3((c - 1) % 3));
            end
            $display("[TB] rr_rotate cycle %0d ready=%b cdb_valid=%b src=%0d", c, r3, cv3, s3);
            @(negedge clk);
        end
        v3 = '0;
        #1;
        tests_run++;
        if (cv3 !== 1'b1 || s3 !== 2'd2 || c3 !== w3(2)) begin
            tests_failed++;
            $display("FAIL rr_rotate_last got cv=%b src=%0d cdb=%h want 1/2/%h", cv3, s3, c3, w3(2));
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (cv3 !== 1'b0 || s3 !== 2'd2 || c3 !== w3(2)) begin
            tests_failed++;
            $display("FAIL idle_hold got cv=%b src=%0d cdb=%h want 0/2/%h", cv3, s3, c3, w3(2));
        end
        $display("[TB] idle cycle holds cdb=%h", c3);
    endtask

    task automatic test_rr_ptr();
        @(negedge clk);
        d3[W +: W] = w3(1);
        v3 = 3'b010;
        #1;
        tests_run++;
        if (r3 !== 3'b010) begin
            tests_failed++;
            $display("FAIL ptr_setup got %b want 010", r3);
        end
        @(negedge clk);
        d3[0 +: W] = 48'h0005_0000_00AB;
        v3 = 3'b001;
        #1;
        tests_run++;
        if (r3 !== 3'b001) begin
            tests_failed++;
            $display("FAIL ptr2_unit0_ready got %b want 001", r3);
        end
        @(negedge clk);
        v3 = 3'b111;
        #1;
        tests_run++;
        if (cv3 !== 1'b1 || c3 !== 48'h0005_0000_00AB || s3 !== 2'd0) begin
            tests_failed++;
            $display("FAIL ptr2_bcast got cv=%b cdb=%h src=%0d want 1/0005000000ab/0", cv3, c3, s3);
        end
        tests_run++;
        if (r3 !== 3'b010) begin
            tests_failed++;
            $display("FAIL ptr_wrap_to_1 got %b want 010", r3);
        end
        $display("[TB] rr_ptr word=%h ptr-follow ready=%b", c3, r3);
        @(negedge clk);
        v3 = '0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        d3[W +: W] = w3(1);
        v3 = 3'b010;
        f3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            tests_run++;
            if (r3 !== 3'b000 || cv3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_block c=%0d got ready=%b cv=%b want 000/0", c, r3, cv3);
            end
            $display("[TB] flush cycle %0d ready=%b cdb_valid=%b", c, r3, cv3);
        end
        @(negedge clk);
        f3 = 1'b0;
        #1;
        tests_run++;
        if (r3 !== 3'b010 || cv3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_release got ready=%b cv=%b want 010/0", r3, cv3);
        end
        @(negedge clk);
        v3 = '0;
        #1;
        tests_run++;
        if (cv3 !== 1'b1 || s3 !== 2'd1 || c3 !== w3(1)) begin
            tests_failed++;
            $display("FAIL flush_after_bcast got cv=%b src=%0d want 1/1", cv3, s3);
        end
        $display("[TB] flush release broadcast src=%0d", s3);
    endtask

    task automatic test_fixed();
        @(negedge clk);
        df = {w3(2), w3(1), w3(0)};
        vf = 3'b110;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (rf !== 3'b010) begin
                tests_failed++;
                $display("FAIL fixed_pri c=%0d got %b want 010", c, rf);
            end
            if (c > 0) begin
                tests_run++;
                if (cvf !== 1'b1 || sf !== 2'd1 || cf !== w3(1)) begin
                    tests_failed++;
                    $display("FAIL fixed_bcast c=%0d got cv=%b src=%0d want 1/1", c, cvf, sf);
                end
            end
            $display("[TB] fixed cycle %0d ready=%b", c, rf);
            @(negedge clk);
        end
        vf = 3'b111;
        #1;
        tests_run++;
        if (rf !== 3'b001) begin
            tests_failed++;
            $display("FAIL fixed_all got %b want 001", rf);
        end
        @(negedge clk);
        vf = 3'b100;
        #1;
        tests_run++;
        if (rf !== 3'b100) begin
            tests_failed++;
            $display("FAIL fixed_only2 got %b want 100", rf);
        end
        $display("[TB] fixed unit2 alone ready=%b", rf);
        @(negedge clk);
        vf = '0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d3 = {w3(2), w3(1), w3(0)};
        v3 = 3'b110;
        #1;
        tests_run++;
        if (r3 !== 3'b100) begin
            tests_failed++;
            $display("FAIL mid_pre_grant got %b want 100", r3);
        end
        #2;
        nrst = 1'b0;
        #1;
        tests_run++;
        if (r3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_reset_ready got %b want 000", r3);
        end
        @(negedge clk);
        nrst = 1'b1;
        v3 = '0;
        #1;
        tests_run++;
        if (cv3 !== 1'b0 || c3 !== '0) begin
            tests_failed++;
            $display("FAIL mid_discard got cv=%b cdb=%h want 0/0", cv3, c3);
        end
        @(negedge clk);
        v3 = 3'b111;
        #1;
        tests_run++;
        if (cv3 !== 1'b0 || r3 !== 3'b001) begin
            tests_failed++;
            $display("FAIL mid_restart got cv=%b ready=%b want 0/001", cv3, r3);
        end
        @(negedge clk);
        v3 = '0;
        #1;
        tests_run++;
        if (cv3 !== 1'b1 || s3 !== 2'd0 || c3 !== w3(0)) begin
            tests_failed++;
            $display("FAIL mid_first_bcast got cv=%b src=%0d want 1/0", cv3, s3);
        end
        $display("[TB] reset mid-transfer restart src=%0d", s3);
    endtask

    task automatic test_random();
        int          ptr5 = 0, gp5 = -1, g, idx, exps5 = 0;
        logic        pend5 = 1'b0, pend1 = 1'b0, gp1 = 1'b0;
        logic [W-1:0] expw5 = '0, expw1 = '0;
        logic [4:0]  exp_r5;
        int          wait5 [5];
        int          err_start;
        err_start = tests_failed;
        for (int i = 0; i < 5; i++) wait5[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (gp5 >= 0) v5[gp5] = 1'b0;
            if (gp1) v1 = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (!v5[i] && $urandom_range(0, 1) == 1) begin
                    v5[i] = 1'b1;
                    d5[i*W +: W] = {16'(i), 32'($urandom)};
                end
            end
            if (!v1 && $urandom_range(0, 1) == 1) begin
                v1 = 1'b1;
                d1 = {16'hF00D, 32'($urandom)};
            end
            f5 = ($urandom_range(0, 7) == 0);
            f1 = ($urandom_range(0, 7) == 0);
            #1;
            tests_run++;
            if (pend5 ? (cv5 !== 1'b1 || c5 !== expw5 || s5 !== 3'(exps5)) : (cv5 !== 1'b0)) begin
                tests_failed++;
                $display("FAIL rand5_bcast cyc=%0d got cv=%b cdb=%h src=%0d want %b/%h/%0d",
                         cyc, cv5, c5, s5, pend5, expw5, exps5);
            end
            tests_run++;
            if (pend1 ? (cv1 !== 1'b1 || c1 !== expw1 || s1 !== 1'b0) : (cv1 !== 1'b0)) begin
                tests_failed++;
                $display("FAIL rand1_bcast cyc=%0d got cv=%b cdb=%h want %b/%h", cyc, cv1, c1, pend1, expw1);
            end
            g = -1;
            if (!f5) begin
                for (int k = 0; k < 5; k++) begin
                    idx = (ptr5 + k) % 5;
                    if (g < 0 && v5[idx]) g = idx;
                end
            end
            exp_r5 = (g >= 0) ? (5'b00001 << g) : 5'b00000;
            tests_run++;
            if (r5 !== exp_r5) begin
                tests_failed++;
                $display("FAIL rand5_ready cyc=%0d got %b want %b", cyc, r5, exp_r5);
            end
            tests_run++;
            if (r1 !== (v1 & ~f1)) begin
                tests_failed++;
                $display("FAIL rand1_ready cyc=%0d got %b want %b", cyc, r1, v1 & ~f1);
            end
            for (int i = 0; i < 5; i++) begin
                if (v5[i] && r5[i]) begin
                    tests_run++;
                    if (wait5[i] > 4) begin
                        tests_failed++;
                        $display("FAIL rr_wait_bound unit=%0d waited %0d want <=4", i, wait5[i]);
                    end
                    wait5[i] = 0;
                end else if (v5[i] && !f5) begin
                    wait5[i]++;
                end
            end
            pend5 = (g >= 0);
            gp5   = g;
            if (g >= 0) begin
                expw5 = d5[g*W +: W];
                exps5 = g;
                ptr5  = (g + 1) % 5;
            end
            pend1 = v1 & ~f1;
            gp1   = pend1;
            if (pend1) expw1 = d1;
        end
        @(negedge clk);
        v5 = '0; v1 = 1'b0; f5 = 1'b0; f1 = 1'b0;
        $display("[TB] random traffic 10000 cycles, %0d new failures", tests_failed - err_start);
    endtask

    initial begin
        test_reset();
        test_rr_rotate();
        test_rr_ptr();
        test_flush();
        test_fixed();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
